// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite region router: response codes, FSM states
// and the address-to-region decode helper.
package axi4_lite_pkg;

  localparam int REGION_IDX_WIDTH = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

  function automatic logic region_mapped(input logic [REGION_IDX_WIDTH-1:0] idx,
                                         input int num_regions);
    return int'(idx) < num_regions;
  endfunction

endpackage

// File: rtl/axi4_lite_req_arbiter.sv
// Two-requester (read/write) bus arbiter with alternating priority on contention
// and a per-grant timeout counter; one downstream request in flight at a time.
module axi4_lite_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic aclk,
  input  logic areset,
  input  logic rd_want,
  input  logic wr_want,
  input  logic hit,
  output logic busy,
  output logic owner_wr,
  output logic done,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;
  logic          prio_wr;
  logic          grant_wr;
  logic          expire;

  // An ack in the final counted cycle wins over the timeout.
  assign expire   = busy && !hit && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign done     = busy && (hit || expire);
  assign timeout  = expire;
  assign grant_wr = wr_want && (!rd_want || prio_wr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy     <= 1'b0;
      owner_wr <= 1'b0;
      cnt      <= '0;
      prio_wr  <= 1'b0;
    end else if (busy) begin
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + CW'(1);
    end else if (rd_want || wr_want) begin
      busy     <= 1'b1;
      owner_wr <= grant_wr;
      cnt      <= '0;
      if (rd_want && wr_want) prio_wr <= !prio_wr;
    end
  end

endmodule

// File: rtl/axi4_lite_region_router.sv
// AXI4-Lite slave front end: decodes addr[top nibble] into regions and drives a
// shared request bus, with independent read/write FSMs and full B/R channels.
module axi4_lite_region_router
  import axi4_lite_pkg::*;
#(
  parameter int pADDR_WIDTH      = 32,
  parameter int pDATA_WIDTH      = 32,
  parameter int NUM_REGIONS      = 4,
  parameter int LOCAL_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [pADDR_WIDTH-1:0]             in_s_awaddr,
  input  logic                               in_s_awvalid,
  output logic                               out_s_awready,
  input  logic [pDATA_WIDTH-1:0]             in_s_wdata,
  input  logic [pDATA_WIDTH/8-1:0]           in_s_wstrb,
  input  logic                               in_s_wvalid,
  output logic                               out_s_wready,
  output logic [1:0]                         out_s_bresp,
  output logic                               out_s_bvalid,
  input  logic                               in_s_bready,
  input  logic [pADDR_WIDTH-1:0]             in_s_araddr,
  input  logic                               in_s_arvalid,
  output logic                               out_s_arready,
  output logic [pDATA_WIDTH-1:0]             out_s_rdata,
  output logic [1:0]                         out_s_rresp,
  output logic                               out_s_rvalid,
  input  logic                               in_s_rready,
  output logic [NUM_REGIONS-1:0]             out_req,
  output logic                               out_we,
  output logic [LOCAL_ADDR_WIDTH-1:0]        out_addr,
  output logic [pDATA_WIDTH-1:0]             out_wdata,
  output logic [pDATA_WIDTH/8-1:0]           out_wstrb,
  input  logic [NUM_REGIONS-1:0]             in_ack,
  input  logic [NUM_REGIONS*pDATA_WIDTH-1:0] in_rdata,
  input  logic [NUM_REGIONS-1:0]             in_err
);

  localparam int IW = REGION_IDX_WIDTH;

  wr_state_t                  wr_state, wr_next;
  rd_state_t                  rd_state, rd_next;
  logic                       ready_en, aw_got, w_got;
  logic [pADDR_WIDTH-1:0]     awaddr_q, araddr_q, aw_cur;
  logic [pDATA_WIDTH-1:0]     wdata_q, rdata_q, sel_rdata;
  logic [pDATA_WIDTH/8-1:0]   wstrb_q;
  resp_t                      bresp_q, rresp_q;
  logic                       aw_hs, w_hs, ar_hs, wr_launch, wr_mapped, rd_mapped;
  logic                       busy, owner_wr, arb_done, arb_timeout, hit, sel_err;
  logic                       wr_done, rd_done;
  logic [IW-1:0]              cur_idx;
  logic                       unused_addr_bits;

  assign aw_hs     = in_s_awvalid && out_s_awready;
  assign w_hs      = in_s_wvalid && out_s_wready;
  assign ar_hs     = in_s_arvalid && out_s_arready;
  assign aw_cur    = aw_got ? awaddr_q : in_s_awaddr;
  assign wr_mapped = region_mapped(aw_cur[pADDR_WIDTH-1 -: IW], NUM_REGIONS);
  assign rd_mapped = region_mapped(in_s_araddr[pADDR_WIDTH-1 -: IW], NUM_REGIONS);
  assign wr_launch = (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_done   = arb_done && owner_wr;
  assign rd_done   = arb_done && !owner_wr;
  assign hit       = |(in_ack & out_req);
  assign sel_err   = |(in_err & in_ack & out_req);

  axi4_lite_req_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_arb (
    .aclk    (aclk),
    .areset  (areset),
    .rd_want (rd_state == R_WAIT),
    .wr_want (wr_state == W_WAIT),
    .hit     (hit),
    .busy    (busy),
    .owner_wr(owner_wr),
    .done    (arb_done),
    .timeout (arb_timeout)
  );

  // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    out_req   = '0;
    sel_rdata = '0;
    cur_idx   = owner_wr ? awaddr_q[pADDR_WIDTH-1 -: IW] : araddr_q[pADDR_WIDTH-1 -: IW];
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (busy && int'(cur_idx) == r) out_req[r] = 1'b1;
      if (out_req[r]) sel_rdata = in_rdata[r*pDATA_WIDTH +: pDATA_WIDTH];
    end
  end

  assign out_we    = busy && owner_wr;
  assign out_addr  = owner_wr ? awaddr_q[LOCAL_ADDR_WIDTH-1:0] : araddr_q[LOCAL_ADDR_WIDTH-1:0];
  assign out_wdata = wdata_q;
  assign out_wstrb = wstrb_q;
  assign out_s_bresp = bresp_q;
  assign out_s_rresp = rresp_q;
  assign out_s_rdata = rdata_q;
  assign unused_addr_bits = ^{awaddr_q[pADDR_WIDTH-IW-1:LOCAL_ADDR_WIDTH],
                              araddr_q[pADDR_WIDTH-IW-1:LOCAL_ADDR_WIDTH]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      ready_en <= 1'b0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (wr_launch) wr_next = wr_mapped ? W_WAIT : W_RESP;
      W_WAIT:  if (wr_done) wr_next = W_RESP;
      W_RESP:  if (in_s_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = rd_mapped ? R_WAIT : R_RESP;
      R_WAIT:  if (rd_done) rd_next = R_RESP;
      R_RESP:  if (in_s_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Readys stay low until the first clock after reset release.
  always_comb begin
    out_s_awready = ready_en && (wr_state == W_IDLE) && !aw_got;
    out_s_wready  = ready_en && (wr_state == W_IDLE) && !w_got;
    out_s_bvalid  = (wr_state == W_RESP);
    out_s_arready = ready_en && (rd_state == R_IDLE);
    out_s_rvalid  = (rd_state == R_RESP);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      if (aw_hs) begin
        awaddr_q <= in_s_awaddr;
        aw_got   <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= in_s_wdata;
        wstrb_q <= in_s_wstrb;
        w_got   <= 1'b1;
      end
      if (wr_launch) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (!wr_mapped) bresp_q <= DECERR;
      end
      if (wr_done) bresp_q <= (arb_timeout || sel_err) ? SLVERR : OKAY;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      araddr_q <= '0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      if (ar_hs) begin
        araddr_q <= in_s_araddr;
        if (!rd_mapped) begin
          rresp_q <= DECERR;
          rdata_q <= '0;
        end
      end
      if (rd_done) begin
        if (arb_timeout) begin
          rresp_q <= SLVERR;
          rdata_q <= '0;
        end else begin
          rresp_q <= sel_err ? SLVERR : OKAY;
          rdata_q <= sel_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_region_router.sv
// Directed bench for axi4_lite_region_router: expected B/R responses are queued
// when a transaction is issued and compared when the DUT presents them.
module tb_axi4_lite_region_router;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [31:0]  in_s_awaddr = '0, in_s_wdata = '0, in_s_araddr = '0;
  logic [3:0]   in_s_wstrb = '0;
  logic         in_s_awvalid = 1'b0, in_s_wvalid = 1'b0, in_s_arvalid = 1'b0;
  logic         in_s_bready = 1'b0, in_s_rready = 1'b0;
  logic         out_s_awready, out_s_wready, out_s_bvalid, out_s_arready, out_s_rvalid;
  logic [1:0]   out_s_bresp, out_s_rresp;
  logic [31:0]  out_s_rdata, out_wdata;
  logic [3:0]   out_req, out_wstrb;
  logic         out_we;
  logic [11:0]  out_addr;
  logic [3:0]   in_ack = '0, in_err = '0;
  logic [127:0] in_rdata = '0;

  exp_t bq[$];
  exp_t rq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   req_cycles = 0;
  int   snap;

  axi4_lite_region_router dut (
    .aclk(aclk), .areset(areset),
    .in_s_awaddr(in_s_awaddr), .in_s_awvalid(in_s_awvalid), .out_s_awready(out_s_awready),
    .in_s_wdata(in_s_wdata), .in_s_wstrb(in_s_wstrb), .in_s_wvalid(in_s_wvalid),
    .out_s_wready(out_s_wready), .out_s_bresp(out_s_bresp), .out_s_bvalid(out_s_bvalid),
    .in_s_bready(in_s_bready), .in_s_araddr(in_s_araddr), .in_s_arvalid(in_s_arvalid),
    .out_s_arready(out_s_arready), .out_s_rdata(out_s_rdata), .out_s_rresp(out_s_rresp),
    .out_s_rvalid(out_s_rvalid), .in_s_rready(in_s_rready), .out_req(out_req),
    .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .in_ack(in_ack), .in_rdata(in_rdata), .in_err(in_err)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (out_req != 4'b0000) req_cycles++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Raise the selected valids together; each drops after its own handshake.
  task automatic send(input string tag, input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [31:0] awa, input logic [31:0] wd, input logic [31:0] ara);
    bit aw_p, w_p, ar_p, hs_aw, hs_w, hs_ar;
    aw_p = do_aw; w_p = do_w; ar_p = do_ar;
    in_s_awaddr = awa; in_s_wdata = wd; in_s_wstrb = 4'hF; in_s_araddr = ara;
    in_s_awvalid = aw_p; in_s_wvalid = w_p; in_s_arvalid = ar_p;
    for (int i = 0; i < 50 && (aw_p || w_p || ar_p); i++) begin
      @(negedge aclk);
      hs_aw = aw_p && out_s_awready;
      hs_w  = w_p && out_s_wready;
      hs_ar = ar_p && out_s_arready;
      @(posedge aclk); #1;
      if (hs_aw) begin aw_p = 1'b0; in_s_awvalid = 1'b0; end
      if (hs_w)  begin w_p = 1'b0;  in_s_wvalid = 1'b0;  end
      if (hs_ar) begin ar_p = 1'b0; in_s_arvalid = 1'b0; end
    end
    check({tag, "_accept"}, {aw_p, w_p, ar_p}, 3'b000);
  endtask

  task automatic wait_req(input string tag, input logic [3:0] req, input logic we,
                          input logic [11:0] addr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (out_req != 4'b0000) begin seen = 1'b1; break; end
    end
    check({tag, "_seen"}, seen, 1'b1);
    check({tag, "_req"}, out_req, req);
    check({tag, "_we"}, out_we, we);
    check({tag, "_addr"}, out_addr, addr);
  endtask

  // Called at a falling edge: one-cycle ack pulse on the given regions.
  task automatic ack_now(input logic [3:0] mask, input logic [31:0] data, input logic [3:0] err);
    for (int r = 0; r < 4; r++)
      in_rdata[r*32 +: 32] = mask[r] ? data : (32'hBAD0_0000 | r);
    in_ack = mask; in_err = err;
    @(posedge aclk); #1;
    in_ack = '0; in_err = '0;
  endtask

  task automatic recv_b(input string tag, input int stall);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (out_s_bvalid) begin seen = 1'b1; break; end
    end
    check({tag, "_bvalid"}, seen, 1'b1);
    e = bq.pop_front();
    check({tag, "_bresp"}, out_s_bresp, e.resp);
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      check({tag, "_bvalid_hold"}, out_s_bvalid, 1'b1);
      check({tag, "_bresp_hold"}, out_s_bresp, e.resp);
    end
    in_s_bready = 1'b1;
    @(posedge aclk); #1 in_s_bready = 1'b0;
    @(negedge aclk);
    check({tag, "_bvalid_drop"}, out_s_bvalid, 1'b0);
    @(posedge aclk); #1;
  endtask

  task automatic recv_r(input string tag, input int stall);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (out_s_rvalid) begin seen = 1'b1; break; end
    end
    check({tag, "_rvalid"}, seen, 1'b1);
    e = rq.pop_front();
    check({tag, "_rresp"}, out_s_rresp, e.resp);
    check({tag, "_rdata"}, out_s_rdata, e.data);
    for (int i = 0; i < stall; i++) begin
      @(negedge aclk);
      check({tag, "_rvalid_hold"}, out_s_rvalid, 1'b1);
      check({tag, "_rdata_hold"}, out_s_rdata, e.data);
    end
    in_s_rready = 1'b1;
    @(posedge aclk); #1 in_s_rready = 1'b0;
    @(negedge aclk);
    check({tag, "_rvalid_drop"}, out_s_rvalid, 1'b0);
    @(posedge aclk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_req", out_req, 4'b0000);
    check("rst_bvalid", out_s_bvalid, 1'b0);
    check("rst_rvalid", out_s_rvalid, 1'b0);
    check("rst_readys", {out_s_awready, out_s_wready, out_s_arready}, 3'b000);
    check("rst_resp", {out_s_bresp, out_s_rresp}, 4'b0000);
    check("rst_rdata", out_s_rdata, 32'h0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    check("rel_readys_low", {out_s_awready, out_s_wready, out_s_arready}, 3'b000);
    @(posedge aclk); #1;
    check("rel_readys_high", {out_s_awready, out_s_wready, out_s_arready}, 3'b111);

    // Write, AW a cycle ahead of W, ack after two extra cycles, B stalled
    bq.push_back(exp_t'{2'b00, 32'h0});
    send("w1_aw", 1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h0, 32'h0);
    send("w1_w", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0005, 32'h0);
    wait_req("w1", 4'b0010, 1'b1, 12'h004);
    check("w1_wdata", out_wdata, 32'h0000_0005);
    check("w1_wstrb", out_wstrb, 4'hF);
    check("w1_readys_wait", {out_s_awready, out_s_wready}, 2'b00);
    repeat (2) @(negedge aclk);
    check("w1_req_held", out_req, 4'b0010);
    ack_now(4'b0010, 32'h0, 4'b0000);
    recv_b("w1", 3);

    // Read region 3, spurious ack on region 0 first
    rq.push_back(exp_t'{2'b00, 32'hDEAD_BEEF});
    send("r1", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h3000_0010);
    wait_req("r1", 4'b1000, 1'b0, 12'h010);
    ack_now(4'b0001, 32'h0BAD_0BAD, 4'b0001);
    @(negedge aclk);
    check("r1_spurious_ignored", out_req, 4'b1000);
    ack_now(4'b1000, 32'hDEAD_BEEF, 4'b0000);
    recv_r("r1", 0);

    // Region error reported as SLVERR on a write
    bq.push_back(exp_t'{2'b10, 32'h0});
    send("w2", 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00AA, 32'h0);
    wait_req("w2", 4'b0001, 1'b1, 12'h100);
    ack_now(4'b0001, 32'h0, 4'b0001);
    recv_b("w2", 0);

    // Unmapped region: DECERR with no downstream request
    snap = req_cycles;
    bq.push_back(exp_t'{2'b11, 32'h0});
    send("w3", 1'b1, 1'b1, 1'b0, 32'h7000_0000, 32'h0000_0099, 32'h0);
    recv_b("w3", 1);
    rq.push_back(exp_t'{2'b11, 32'h0});
    send("r3", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h7000_0000);
    recv_r("r3", 1);
    check("decerr_no_req", req_cycles - snap, 0);

    // Timeout: region 2 never acks
    snap = req_cycles;
    rq.push_back(exp_t'{2'b10, 32'h0});
    send("r4", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h2000_0000);
    wait_req("r4", 4'b0100, 1'b0, 12'h000);
    recv_r("r4", 0);
    check("r4_req_cycles", req_cycles - snap, 64);

    // Ack in the 64th request cycle takes priority over the timeout
    snap = req_cycles;
    rq.push_back(exp_t'{2'b00, 32'h1234_5678});
    send("r5", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h2000_0008);
    wait_req("r5", 4'b0100, 1'b0, 12'h008);
    repeat (63) @(negedge aclk);
    ack_now(4'b0100, 32'h1234_5678, 4'b0000);
    recv_r("r5", 0);
    check("r5_req_cycles", req_cycles - snap, 64);

    // Contention: read wins first, write wins second
    rq.push_back(exp_t'{2'b00, 32'hA5A5_0001});
    bq.push_back(exp_t'{2'b00, 32'h0});
    send("alt1", 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0011, 32'h0000_0020);
    wait_req("alt1_first", 4'b0001, 1'b0, 12'h020);
    ack_now(4'b0001, 32'hA5A5_0001, 4'b0000);
    wait_req("alt1_second", 4'b0001, 1'b1, 12'h030);
    ack_now(4'b0001, 32'h0, 4'b0000);
    recv_r("alt1", 0);
    recv_b("alt1", 0);

    rq.push_back(exp_t'{2'b00, 32'hA5A5_0002});
    bq.push_back(exp_t'{2'b00, 32'h0});
    send("alt2", 1'b1, 1'b1, 1'b1, 32'h0000_0034, 32'h0000_0022, 32'h0000_0024);
    wait_req("alt2_first", 4'b0001, 1'b1, 12'h034);
    ack_now(4'b0001, 32'h0, 4'b0000);
    wait_req("alt2_second", 4'b0001, 1'b0, 12'h024);
    ack_now(4'b0001, 32'hA5A5_0002, 4'b0000);
    recv_r("alt2", 0);
    recv_b("alt2", 0);

    // Reset while a read is waiting for ack
    send("r6", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_0040);
    wait_req("r6", 4'b0001, 1'b0, 12'h040);
    #2 areset = 1'b1;
    #1;
    check("r6_rst_req", out_req, 4'b0000);
    check("r6_rst_rvalid", out_s_rvalid, 1'b0);
    check("r6_rst_arready", out_s_arready, 1'b0);
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("r6_rel_arready_low", out_s_arready, 1'b0);
    @(posedge aclk); #1;
    check("r6_rel_arready_high", out_s_arready, 1'b1);

    rq.push_back(exp_t'{2'b00, 32'hCAFE_F00D});
    send("r7", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1000_0008);
    wait_req("r7", 4'b0010, 1'b0, 12'h008);
    ack_now(4'b0010, 32'hCAFE_F00D, 4'b0000);
    recv_r("r7", 0);

    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_region_router.md
Name: axi4_lite_region_router

Overview:
- Parametrised next-generation AXI4-Lite slave front end for the FIR accelerator.
- Decodes the top address nibble into NUM_REGIONS downstream register/BRAM regions and drives one shared request bus with per-region request/ack.
- Adds what the current slave lacks: a full B channel, OKAY/SLVERR/DECERR responses, independent read/write FSMs with read/write alternation, and a per-request timeout.

Parameters:
- pADDR_WIDTH, 32, AXI address width.
- pDATA_WIDTH, 32, AXI data width (multiple of 8).
- NUM_REGIONS, 4, number of mapped regions (1..16); region index = addr[pADDR_WIDTH-1 -: 4].
- LOCAL_ADDR_WIDTH, 12, offset bits forwarded downstream (addr[LOCAL_ADDR_WIDTH-1:0]).
- TIMEOUT_CYCLES, 64, cycles without ack before SLVERR (>=2).

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- in_s_awaddr  in  pADDR_WIDTH  write address.
- in_s_awvalid  in  1 / out_s_awready  out  1  AW handshake.
- in_s_wdata  in  pDATA_WIDTH  write data.
- in_s_wstrb  in  pDATA_WIDTH/8  byte strobes.
- in_s_wvalid  in  1 / out_s_wready  out  1  W handshake.
- out_s_bresp  out  2  write response.
- out_s_bvalid  out  1 / in_s_bready  in  1  B handshake.
- in_s_araddr  in  pADDR_WIDTH  read address.
- in_s_arvalid  in  1 / out_s_arready  out  1  AR handshake.
- out_s_rdata  out  pDATA_WIDTH  read data.
- out_s_rresp  out  2  read response.
- out_s_rvalid  out  1 / in_s_rready  in  1  R handshake.
- out_req  out  NUM_REGIONS  one-hot downstream request, held until ack.
- out_we  out  1  1 = write request, 0 = read request.
- out_addr  out  LOCAL_ADDR_WIDTH  local offset.
- out_wdata  out  pDATA_WIDTH  write data.
- out_wstrb  out  pDATA_WIDTH/8  byte enables.
- in_ack  in  NUM_REGIONS  per-region completion pulse.
- in_rdata  in  NUM_REGIONS*pDATA_WIDTH  per-region read data, valid with ack.
- in_err  in  NUM_REGIONS  per-region error, valid with ack.

Behaviour:
- Reset (async, immediate): all valid/req outputs 0; ready outputs 0; resp = 2'b00; rdata = 0; FSMs to IDLE; timeout counter = 0; alternation pointer = read. Readys rise on the first clock after reset release.
- Response codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP.
  - W_IDLE: awready=1 until AW is latched; wready=1 until W is latched. AW and W are accepted in either order or in the same cycle.
  - When both are latched: region index >= NUM_REGIONS goes straight to W_RESP with DECERR (no downstream request); otherwise go to W_WAIT.
  - W_WAIT: request the arbiter, then hold out_req/out_we=1 until in_ack. in_err selects SLVERR, else OKAY. Timeout gives SLVERR.
  - W_RESP: bvalid=1 and bresp stable until bready, then W_IDLE. awready/wready stay 0 in W_WAIT and W_RESP.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP, same structure.
  - arready=1 only in R_IDLE.
  - Unmapped region gives DECERR with rdata=0.
  - On ack: capture the selected in_rdata slice.
  - Timeout gives SLVERR with rdata=0.
  - rvalid/rdata/rresp held stable until rready.
- Arbiter: one downstream request at a time. If read and write both want the bus in the same cycle, grant the side not granted last, then toggle the pointer. A grant is held until ack or timeout.
- Request timing: out_req rises 1 cycle after the grant. Minimum latency, aligned AW+W to bvalid: 3 cycles with ack in the first request cycle (latch, req, resp).
- Timeout: counter resets on each grant and increments while req is high. At TIMEOUT_CYCLES it drops req and sets SLVERR. An ack arriving in that same cycle takes priority (normal response).
- A spurious ack, or an ack on an unrequested region, is ignored.
- Same address read and write concurrently: the ordering is whichever the arbiter picks; no hazard protection.

Decomposition:
- Package axi4_lite_pkg: resp_t enum (OKAY, SLVERR, DECERR), wr_state_t, rd_state_t, REGION_IDX_WIDTH=4.
- Sub-module axi4_lite_req_arbiter: 2-requester alternating arbiter plus timeout counter, parametrised by TIMEOUT_CYCLES.

Test Plan:
- Write 0x0000_0005 to 0x1000_0004, AW one cycle before W, ack after 2 cycles -> out_req=4'b0010, out_addr=0x004, wstrb=4'hF; bresp=OKAY; bvalid held 3 cycles while bready=0.
- Read 0x3000_0010 with region 3 returning 0xDEAD_BEEF on ack -> rdata=0xDEAD_BEEF, rresp=OKAY; no req on regions 0-2.
- Write to 0x7000_0000 (NUM_REGIONS=4) -> bresp=DECERR, out_req never asserted; read of the same address -> rresp=DECERR, rdata=0.
- Region 2 never acks -> out_req drops after 64 cycles, rresp=SLVERR. A second run with ack in cycle 64 -> OKAY.
- AR and AW+W to region 0 in the same cycle, twice -> grants alternate read, write, then write, read; each completes with OKAY.
- Assert areset while in R_WAIT -> out_req and rvalid go to 0 immediately; after release a fresh read completes normally.
